chunk_subtract: RTL

- Multi-cycle operand subtractor: computes src_a - src_b one CHUNK_WIDTH slice per cycle, LSB chunk first.
- Output is the raw two's-complement difference plus the forwarded control word.
- Sits directly upstream of the ALU compare stage, which reads the sign bit and the zero condition of the difference for slt/sgt.
- Uses valid/ready handshakes on both sides so that it can be stalled by the downstream pipeline.

---
 rtl/alu_pkg.sv | 11 +
 rtl/chunk_adder.sv | 18 +
 rtl/chunk_subtract.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state type, chunk sizing helpers and ALU control constants.
package alu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int SLT_BIT = 3;
  function automatic int num_chunks(input int src_w, input int chunk_w);
    return src_w / chunk_w;
  endfunction
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit adder exposing carry-out and the carry into the MSB.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] full;
  assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = full[W-1:0];
  assign cout  = full[W];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the full sum.
  assign c_msb = full[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/chunk_subtract.sv
// chunk_subtract: multi-cycle src_a - src_b, one CHUNK_WIDTH slice per cycle, LSB first.
module chunk_subtract
  import alu_pkg::*;
#(
  parameter int SRC_WIDTH     = 32,
  parameter int CHUNK_WIDTH   = 8,
  parameter int CONTROL_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SRC_WIDTH-1:0]     src_a,
  input  logic [SRC_WIDTH-1:0]     src_b,
  input  logic [CONTROL_WIDTH-1:0] control_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SRC_WIDTH-1:0]     diff,
  output logic [CONTROL_WIDTH-1:0] control_out,
  output logic                     overflow
);
  localparam int NC = num_chunks(SRC_WIDTH, CHUNK_WIDTH);
  localparam int CW = cnt_width(NC);
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     carry_q, carry_d;
  logic [SRC_WIDTH-1:0]     a_q, a_d, nb_q, nb_d, diff_q, diff_d;
  logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                     ovf_q, ovf_d;
  logic [CHUNK_WIDTH-1:0]   a_chunk, nb_chunk, sum;
  logic                     cout, c_msb, last;
  assign a_chunk  = a_q[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign nb_chunk = nb_q[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign last     = (cnt_q == CW'(NC - 1));
  chunk_adder #(.W(CHUNK_WIDTH)) u_add (
    .a    (a_chunk),
    .b    (nb_chunk),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout),
    .c_msb(c_msb)
  );
  // Subtraction as a + ~b + 1: b is inverted at capture and the +1 seeds the carry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    nb_d    = nb_q;
    diff_d  = diff_q;
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = src_a;
      nb_d    = ~src_b;
      ctrl_d  = control_in;
      carry_d = 1'b1;
      cnt_d   = '0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      diff_d[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = sum;
      carry_d = cout;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      ovf_d   = last ? (c_msb ^ cout) : ovf_q;
      state_d = last ? DONE : BUSY;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
      ctrl_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      diff_q  <= diff_d;
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign diff        = diff_q;
  assign control_out = ctrl_q;
  assign overflow    = ovf_q;
endmodule
